mem_tlb_walk: RTL
=================

MEM_TLB_WALK -- requirements
Module: mem_tlb_walk

Interface
REQ-001 SHALL have parameter WALK_LEVELS, default 4, the number of page-table levels; each level indexes 9 VA bits, the top level starting at VA[47:39].
REQ-002 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-003 SHALL have ports: reset  in  1  synchronous, active-low reset.
REQ-004 SHALL have ports: missReq  in  1  TLB miss report; missAddr  in  64  faulting virtual address.
REQ-005 SHALL have ports: busy  out  1  walk in progress; walkDone  out  1  one-cycle success pulse; walkFault  out  1  one-cycle fault pulse.
REQ-006 SHALL have ports: memReq  out  1  page-table read request; memAddr  out  40  read address; memRdata  in  64  read data; memAck  in  1  read complete.
REQ-007 SHALL have ports: tlbOpMode  out  3  MMU op (0 NONE, 2 GETREG, 3 SETREG, 4 LDTLB); tlbOpReg  out  3  MMU register (1 PTEH, 2 PTEL, 3 TTB, 4 TEA); tlbOutAddr  out  64  MMU data in; tlbInAddr  in  64  MMU data out.

Function
REQ-008 SHALL use states IDLE, GETTTB, READ, SETPTEH, SETPTEL, LDTLB, SETTEA, DONE, FAULT.
REQ-009 SHALL, in IDLE with missReq=1, latch missAddr, clear the level counter to 0, and go to GETTTB; missReq SHALL be ignored in every other state.
REQ-010 SHALL, in GETTTB, drive opMode=2/opReg=3, capture tlbInAddr[39:12] as the table base at the clock edge, and go to READ.
REQ-011 SHALL, in READ, hold memReq=1 and memAddr={base[39:12], index[8:0], 3'b000} stable until memAck=1; index is VA[47-9*L : 39-9*L] at level L.
REQ-012 SHALL sample memRdata on the memAck cycle; PTE bit 0 = valid, bits [39:12] = next-table or page frame.
REQ-013 SHALL, when the PTE is invalid, go to SETTEA (or FAULT, per REQ-023).
REQ-014 SHALL, when the PTE is valid and L < WALK_LEVELS-1, load base from PTE[39:12], increment L, and stay in READ.
REQ-015 SHALL, when the PTE is valid at the last level, go to SETPTEH.
REQ-016 SHALL drive, each for exactly one cycle: SETPTEH opMode=3/opReg=1/tlbOutAddr={16'h0, VA[47:12], 12'h0}; SETPTEL opMode=3/opReg=2/tlbOutAddr={24'h0, PTE[39:12], 12'h0}; LDTLB opMode=4.
REQ-017 SHALL proceed SETPTEH -> SETPTEL -> LDTLB -> DONE -> IDLE.
REQ-018 SHALL, in SETTEA, drive opMode=3/opReg=4/tlbOutAddr=latched missAddr for one cycle, then go to FAULT -> IDLE.
REQ-019 SHALL assert walkDone only in DONE and walkFault only in FAULT, and assert busy in every state except IDLE.
REQ-020 SHALL drive tlbOpMode=0, tlbOpReg=0, tlbOutAddr=0 in all states not listed in REQ-010/016/018; memReq=0 outside READ.
REQ-021 Latency with memAck tied to memReq and WALK_LEVELS=4: walkDone high in the 9th cycle after the edge that accepts missReq; each memAck wait cycle adds one cycle.

Reset
REQ-022 SHALL, on any clk edge with reset=0, including mid-walk and mid-READ, enter IDLE, zero the level counter, base, and latched VA, and drive all outputs to 0 from the next cycle; an outstanding memAck SHALL then be ignored.

Configuration
REQ-023 SHALL, with MEM_TLB_WALK_TEA_EN defined, route invalid-PTE faults through SETTEA; without it, go directly from READ to FAULT and never issue opReg=4.

Verification
REQ-024 TTB=0x0000100000, all four PTEs valid, leaf PTE=0x0000ABC001, missAddr=0x000012345678, zero-wait ack -> reads at 0x0000100000/+..., then SETREG PTEH=0x0000_1234_5000, PTEL=0x00_0ABC_000 frame, LDTLB, walkDone in cycle 9.
REQ-025 Same setup, memAck delayed 3 cycles per read -> memAddr/memReq stable throughout, walkDone in cycle 21.
REQ-026 Level-1 PTE=0, MEM_TLB_WALK_TEA_EN defined -> exactly two reads, SETREG TEA=missAddr, walkFault one cycle, no LDTLB.
REQ-027 Same as REQ-026 with macro undefined -> walkFault directly after second read, no opReg=4 ever.
REQ-028 reset=0 during the third READ with memAck pending -> all outputs 0 next cycle, busy=0, new missReq then walks from GETTTB.
REQ-029 missReq held high through a walk -> second walk starts only after returning to IDLE; no extra ops during the first.

Source files
------------

// File: rtl/mem_tlb_walk_if.sv
// Miss-report, page-table read and MMU register ports of the hardware page walker.
// The walker takes the slave side; the TLB/memory/MMU environment takes the master side.
interface mem_tlb_walk_if;
    logic        missReq;
    logic [63:0] missAddr;
    logic        busy;
    logic        walkDone;
    logic        walkFault;
    logic        memReq;
    logic [39:0] memAddr;
    logic [63:0] memRdata;
    logic        memAck;
    logic [2:0]  tlbOpMode;
    logic [2:0]  tlbOpReg;
    logic [63:0] tlbOutAddr;
    logic [63:0] tlbInAddr;

    modport slave (
        input  missReq, missAddr, memRdata, memAck, tlbInAddr,
        output busy, walkDone, walkFault, memReq, memAddr, tlbOpMode, tlbOpReg, tlbOutAddr
    );

    modport master (
        output missReq, missAddr, memRdata, memAck, tlbInAddr,
        input  busy, walkDone, walkFault, memReq, memAddr, tlbOpMode, tlbOpReg, tlbOutAddr
    );
endinterface

// File: rtl/mem_tlb_walk.sv
// Hardware page-table walker: TTB fetch, WALK_LEVELS reads of 9-bit-indexed tables, PTEH/PTEL/LDTLB load.
// Define MEM_TLB_WALK_TEA_EN to report the faulting address through SETREG TEA before the fault pulse.
module mem_tlb_walk #(
    parameter int WALK_LEVELS = 4
) (
    input logic          clk,
    input logic          reset,
    mem_tlb_walk_if.slave bus
);
    localparam int LW = (WALK_LEVELS > 1) ? $clog2(WALK_LEVELS) : 1;
    localparam logic [LW-1:0] LAST_LEVEL = LW'(WALK_LEVELS - 1);

    localparam logic [2:0] OP_NONE   = 3'd0;
    localparam logic [2:0] OP_GETREG = 3'd2;
    localparam logic [2:0] OP_SETREG = 3'd3;
    localparam logic [2:0] OP_LDTLB  = 3'd4;
    localparam logic [2:0] REG_PTEH  = 3'd1;
    localparam logic [2:0] REG_PTEL  = 3'd2;
    localparam logic [2:0] REG_TTB   = 3'd3;
`ifdef MEM_TLB_WALK_TEA_EN
    localparam logic [2:0] REG_TEA   = 3'd4;
`endif

    typedef enum logic [3:0] {
        IDLE, GETTTB, READ, SETPTEH, SETPTEL, LDTLB, SETTEA, DONE, FAULT
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [LW-1:0] r_level;
    logic [27:0]   r_base;
    logic [63:0]   r_va;

    logic [8:0]    w_index_tab [WALK_LEVELS];
    logic [8:0]    w_index;
    logic          w_last_level;
    logic          w_busy;
    logic          w_walk_done;
    logic          w_walk_fault;
    logic          w_mem_req;
    logic [39:0]   w_mem_addr;
    logic [2:0]    w_op_mode;
    logic [2:0]    w_op_reg;
    logic [63:0]   w_out_addr;
    logic          w_unused_bits;

    // Level L indexes VA[47-9L : 39-9L]
    generate
        for (genvar gi = 0; gi < WALK_LEVELS; gi++) begin : g_index
            assign w_index_tab[gi] = r_va[47-9*gi -: 9];
        end
    endgenerate

    assign w_index      = w_index_tab[r_level];
    assign w_last_level = (r_level == LAST_LEVEL);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_level <= '0;
            r_base  <= '0;
            r_va    <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (bus.missReq) begin
                        r_va    <= bus.missAddr;
                        r_level <= '0;
                    end
                end
                GETTTB: r_base <= bus.tlbInAddr[39:12];
                READ: begin
                    // At the leaf this leaves the page frame in r_base for SETPTEL
                    if (bus.memAck && bus.memRdata[0]) begin
                        r_base <= bus.memRdata[39:12];
                        if (!w_last_level) begin
                            r_level <= r_level + LW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b1;
        w_walk_done  = 1'b0;
        w_walk_fault = 1'b0;
        w_mem_req    = 1'b0;
        w_mem_addr   = '0;
        w_op_mode    = OP_NONE;
        w_op_reg     = 3'd0;
        w_out_addr   = '0;
        case (r_state)
            IDLE: begin
                w_busy = 1'b0;
                if (bus.missReq) begin
                    w_state_next = GETTTB;
                end
            end
            GETTTB: begin
                w_op_mode    = OP_GETREG;
                w_op_reg     = REG_TTB;
                w_state_next = READ;
            end
            READ: begin
                w_mem_req  = 1'b1;
                w_mem_addr = {r_base, w_index, 3'b000};
                if (bus.memAck) begin
                    if (!bus.memRdata[0]) begin
`ifdef MEM_TLB_WALK_TEA_EN
                        w_state_next = SETTEA;
`else
                        w_state_next = FAULT;
`endif
                    end else if (w_last_level) begin
                        w_state_next = SETPTEH;
                    end
                end
            end
            SETPTEH: begin
                w_op_mode    = OP_SETREG;
                w_op_reg     = REG_PTEH;
                w_out_addr   = {16'h0, r_va[47:12], 12'h0};
                w_state_next = SETPTEL;
            end
            SETPTEL: begin
                w_op_mode    = OP_SETREG;
                w_op_reg     = REG_PTEL;
                w_out_addr   = {24'h0, r_base, 12'h0};
                w_state_next = LDTLB;
            end
            LDTLB: begin
                w_op_mode    = OP_LDTLB;
                w_state_next = DONE;
            end
            SETTEA: begin
`ifdef MEM_TLB_WALK_TEA_EN
                w_op_mode  = OP_SETREG;
                w_op_reg   = REG_TEA;
                w_out_addr = r_va;
`endif
                w_state_next = FAULT;
            end
            DONE: begin
                w_walk_done  = 1'b1;
                w_state_next = IDLE;
            end
            FAULT: begin
                w_walk_fault = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign bus.busy       = w_busy;
    assign bus.walkDone   = w_walk_done;
    assign bus.walkFault  = w_walk_fault;
    assign bus.memReq     = w_mem_req;
    assign bus.memAddr    = w_mem_addr;
    assign bus.tlbOpMode  = w_op_mode;
    assign bus.tlbOpReg   = w_op_reg;
    assign bus.tlbOutAddr = w_out_addr;

    // PTE attribute bits and VA bits outside the walked range are deliberately ignored
    assign w_unused_bits = ^{bus.tlbInAddr[63:40], bus.tlbInAddr[11:0],
                             bus.memRdata[63:40], bus.memRdata[11:1],
                             r_va[63:48], r_va[11:0]};
endmodule
